code_patch_loader: RTL
======================

Name: code_patch_loader

Overview:
Serial-interface write side of the code-patch table: the loader for what the patch core reads. Receives bit-serial patch frames, each carrying a table index and a 22-bit patch word. Commits each frame into a small register table and presents every entry plus its valid flag to the patch core. Writes are gated by the same pattern-generation config enable the core uses.

Parameters:
ENTRY_W, 22, width of one patch word
NUM_ENTRIES, 3, number of patch table entries
IDX_W, 2, index field width; frame length FRAME_W = IDX_W + ENTRY_W (24)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
cfg_pat_gen_i  input  1  write enable; when low, frames are not accepted
si_valid_i  input  1  qualifies si_data_i / si_start_i this cycle
si_start_i  input  1  first bit of a frame (meaningful only when si_valid_i=1)
si_data_i  input  1  serial data bit, MSB first
si_clear_i  input  1  synchronous clear of all valid flags
patch_entry_o  output  NUM_ENTRIES x ENTRY_W  patch table contents
patch_valid_o  output  NUM_ENTRIES  per-entry valid flags
wr_done_o  output  1  one-cycle pulse: frame committed
wr_err_o  output  1  one-cycle pulse: frame rejected or aborted
busy_o  output  1  high while in SHIFT or COMMIT

Behaviour:
- Reset (rst_ni=0, async): patch_entry_o all 0, patch_valid_o all 0, wr_done_o=0, wr_err_o=0, busy_o=0, FSM=IDLE, bit counter=0.
- Frame format: IDX_W index bits, then ENTRY_W data bits, both MSB first; one bit accepted per cycle with si_valid_i=1. Gaps (si_valid_i=0) allowed anywhere in the frame.
- FSM states IDLE, SHIFT, COMMIT.
- IDLE: if si_valid_i & si_start_i & cfg_pat_gen_i, shift the bit in, set count=1, go to SHIFT. si_valid_i without si_start_i is ignored.
- SHIFT: on each si_valid_i & !si_start_i, shift the bit in and increment count. The cycle that accepts bit FRAME_W moves to COMMIT.
- SHIFT, si_valid_i & si_start_i (new frame mid-frame): pulse wr_err_o. The current frame is discarded. That bit becomes bit 1 of a new frame (count=1) and the FSM stays in SHIFT.
- SHIFT, cfg_pat_gen_i=0: abort to IDLE, pulse wr_err_o, discard the frame. The bit presented in that cycle is ignored.
- COMMIT (one cycle, accepts no input bits):
  - If index < NUM_ENTRIES: write the entry, set its valid flag, pulse wr_done_o.
  - Otherwise: write nothing and pulse wr_err_o.
  - Always return to IDLE.
- Latency: the final data bit is accepted in cycle N and COMMIT is cycle N+1. patch_entry_o, patch_valid_o and wr_done_o/wr_err_o change on the clock edge ending cycle N+1. A new start bit is accepted no earlier than cycle N+2. A start bit presented during COMMIT is dropped silently.
- Rewriting an already-valid entry overwrites it; its valid flag stays 1.
- si_clear_i=1: all valid flags go to 0 on the next edge; entry data is retained.
  - If COMMIT coincides with clear, clear wins: no write, all flags 0, wr_err_o pulses instead of wr_done_o.
  - Clear does not disturb an in-progress SHIFT.
- wr_done_o and wr_err_o are registered, mutually exclusive, and high for exactly one cycle per event.
- busy_o = (state != IDLE), registered with the state.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.
- Index comparison is unsigned over IDX_W bits; with IDX_W=2, index 3 is out of range.

Test Plan:
- Reset, cfg=1, send frame idx=1 data=22'h2A5A5A without gaps -> COMMIT cycle N+1; on the edge ending N+1, patch_entry_o[1]=22'h2A5A5A, patch_valid_o=3'b010, wr_done_o one cycle; entries 0/2 stay 0.
- Send idx=3 data=22'h3FFFFF -> wr_err_o one cycle; table and valid flags unchanged; busy_o low after COMMIT.
- Send frame idx=0 with random si_valid_i gaps, then idx=0 data=22'h000001 -> entry0=22'h000001, valid[0]=1, two wr_done_o pulses.
- Assert si_start_i at bit 10 of a frame to idx=2, then complete a fresh idx=2 data=22'h155555 frame -> one wr_err_o at bit 10; entry2=22'h155555, valid[2]=1, one wr_done_o.
- Deassert cfg_pat_gen_i mid-frame -> wr_err_o, FSM IDLE, no write. Then assert si_clear_i in the COMMIT cycle of a valid frame -> patch_valid_o=0, wr_err_o, no wr_done_o.
- Pull rst_ni low at bit 15 of a frame, release, send one full frame -> all outputs 0 during reset; the subsequent frame commits normally.

Source files
------------

// File: rtl/code_patch_loader.sv
// -----------------------------------------------------------------------------
// code_patch_loader
// Write side of the code-patch table. Deserialises bit-serial patch frames
// ({index, patch word}, MSB first) and commits each into a small register
// table that the patch core reads together with per-entry valid flags.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   cfg_pat_gen_i  write enable; low blocks new frames and aborts a frame
//   si_valid_i     qualifies si_start_i / si_data_i this cycle
//   si_start_i     first bit of a frame
//   si_data_i      serial data bit, MSB first
//   si_clear_i     synchronous clear of all valid flags (data retained)
//   patch_entry_o  table contents, one ENTRY_W word per entry
//   patch_valid_o  per-entry valid flags
//   wr_done_o      one-cycle pulse: frame committed
//   wr_err_o       one-cycle pulse: frame rejected or aborted
//   busy_o         high while a frame is being shifted or committed
// -----------------------------------------------------------------------------
module code_patch_loader #(
    parameter int ENTRY_W     = 22,
    parameter int NUM_ENTRIES = 3,
    parameter int IDX_W       = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  cfg_pat_gen_i,
    input  logic                                  si_valid_i,
    input  logic                                  si_start_i,
    input  logic                                  si_data_i,
    input  logic                                  si_clear_i,
    output logic [NUM_ENTRIES-1:0][ENTRY_W-1:0]   patch_entry_o,
    output logic [NUM_ENTRIES-1:0]                patch_valid_o,
    output logic                                  wr_done_o,
    output logic                                  wr_err_o,
    output logic                                  busy_o
);

    // state  | meaning
    // IDLE   | waiting for a start bit with cfg_pat_gen_i high
    // SHIFT  | collecting frame bits; count = bits accepted so far
    // COMMIT | one cycle: write entry (or reject), no bits accepted

    localparam int FRAME_W = IDX_W + ENTRY_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                               state_q, state_d;
    logic [FRAME_W-1:0]                   shreg_q, shreg_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [NUM_ENTRIES-1:0][ENTRY_W-1:0]  entry_q, entry_d;
    logic [NUM_ENTRIES-1:0]               valid_q, valid_d;
    logic                                 done_q, done_d;
    logic                                 err_q, err_d;
    logic                                 busy_q;

    logic [IDX_W-1:0]   frame_idx;
    logic [ENTRY_W-1:0] frame_data;

    assign frame_idx  = shreg_q[FRAME_W-1 -: IDX_W];
    assign frame_data = shreg_q[ENTRY_W-1:0];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        entry_d = entry_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // Clear only touches the flags, so it never disturbs shifting.
        if (si_clear_i) begin
            valid_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (si_valid_i && si_start_i && cfg_pat_gen_i) begin
                    shreg_d = {{(FRAME_W-1){1'b0}}, si_data_i};
                    cnt_d   = CNT_W'(1);
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (!cfg_pat_gen_i) begin
                    // Abort takes priority over whatever bit is presented.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (si_valid_i) begin
                    if (si_start_i) begin
                        // Restart: the start bit opens a fresh frame.
                        err_d   = 1'b1;
                        shreg_d = {{(FRAME_W-1){1'b0}}, si_data_i};
                        cnt_d   = CNT_W'(1);
                    end else begin
                        shreg_d = {shreg_q[FRAME_W-2:0], si_data_i};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_COMMIT;
                        end
                    end
                end
            end

            ST_COMMIT: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                if (si_clear_i || (int'(frame_idx) >= NUM_ENTRIES)) begin
                    err_d = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_ENTRIES; i++) begin
                        if (int'(frame_idx) == i) begin
                            entry_d[i] = frame_data;
                            valid_d[i] = 1'b1;
                        end
                    end
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            entry_q <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            entry_q <= entry_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign patch_entry_o = entry_q;
    assign patch_valid_o = valid_q;
    assign wr_done_o     = done_q;
    assign wr_err_o      = err_q;
    assign busy_o        = busy_q;

endmodule
